// File: rtl/jcn_pkg.sv
// Shared definitions for the jump/branch/interrupt controller.
//   - 6-bit opcode encodings recognised by the controller
//   - flag bit positions inside flag_ex (zero, carry)
//   - per-cycle action kinds resolved by the top-level decode
//   - vector address helper: base + index * stride
package jcn_pkg;

  localparam logic [5:0] OP_RETI = 6'h10;
  localparam logic [5:0] OP_JMP  = 6'h18;
  localparam logic [5:0] OP_JC   = 6'h1C;
  localparam logic [5:0] OP_JNC  = 6'h1D;
  localparam logic [5:0] OP_JZ   = 6'h1E;
  localparam logic [5:0] OP_JNZ  = 6'h1F;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_C = 1;

  typedef enum logic [1:0] {
    ACT_NONE,
    ACT_BRANCH,
    ACT_TAKE,
    ACT_RETI
  } act_e;

  // Caller truncates the result to its address width (wraps mod 2^AW).
  function automatic logic [31:0] vec_calc(input logic [31:0] base,
                                           input logic [31:0] stride,
                                           input logic [31:0] idx);
    return base + stride * idx;
  endfunction

endpackage

// File: rtl/jcn_ret_stack.sv
// Synchronous LIFO holding {flags, return address} entries.
//   clk, reset : clock, synchronous active-high reset (clears occupancy)
//   push, din  : write din on top when not full
//   pop        : drop top entry when not empty
//   top        : current top entry (undefined while empty)
//   full/empty : occupancy flags; count : number of stored entries
// A simultaneous push and pop leaves the LIFO unchanged.
module jcn_ret_stack #(
  parameter int unsigned W     = 18,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW   = $clog2(DEPTH + 1),
  localparam int unsigned IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  top,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign wr_idx  = IW'(count);
  assign rd_idx  = IW'(count - CW'(1));
  assign top     = mem[rd_idx];
  assign do_push = push && !pop && !full;
  assign do_pop  = pop && !push && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (do_push) begin
      count <= count + CW'(1);
    end else if (do_pop) begin
      count <= count - CW'(1);
    end
  end

  // Storage needs no reset: entries above count are never read.
  always_ff @(posedge clk) begin
    if (!reset && do_push) begin
      mem[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/jump_control_nested.sv
// Jump/branch/interrupt controller between decode and the PC mux.
//   clk, reset       : clock, synchronous active-high reset
//   op               : opcode in execute
//   jmp_address_pm   : branch target from program memory
//   current_address  : PC of the instruction in execute
//   flag_ex          : ALU flags (bit0 zero, bit1 carry)
//   irq              : level interrupt requests, edge-detected here
//   jmp_loc          : next PC when pc_mux_sel is high
//   pc_mux_sel       : one-cycle select of jmp_loc
//   flag_restore(_en): flags popped by RETI and their load strobe
//   irq_ack          : one-hot, one-cycle acknowledge of the taken source
//   isr_depth        : return-stack occupancy
//   err_underflow    : sticky, RETI seen with an empty stack
module jump_control_nested
  import jcn_pkg::*;
#(
  parameter int unsigned    AW         = 16,
  parameter int unsigned    FW         = 2,
  parameter int unsigned    NIRQ       = 4,
  parameter int unsigned    DEPTH      = 4,
  parameter logic [AW-1:0]  VEC_BASE   = 16'h00F0,
  parameter int unsigned    VEC_STRIDE = 4,
  localparam int unsigned   DW         = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [5:0]      op,
  input  logic [AW-1:0]   jmp_address_pm,
  input  logic [AW-1:0]   current_address,
  input  logic [FW-1:0]   flag_ex,
  input  logic [NIRQ-1:0] irq,
  output logic [AW-1:0]   jmp_loc,
  output logic            pc_mux_sel,
  output logic [FW-1:0]   flag_restore,
  output logic            flag_restore_en,
  output logic [NIRQ-1:0] irq_ack,
  output logic [DW-1:0]   isr_depth,
  output logic            err_underflow
);

  localparam int unsigned XW = (NIRQ > 1) ? $clog2(NIRQ) : 1;

  logic [NIRQ-1:0]  irq_q;
  logic [NIRQ-1:0]  pending;
  logic             shadow;

  logic [NIRQ-1:0]  win_hot;
  logic [XW-1:0]    win_idx;
  logic             found;
  logic             branch;
  logic             is_reti;
  logic             take;
  logic             underflow;
  logic             push;
  logic             pop;
  logic [AW-1:0]    ret_addr;
  logic [AW-1:0]    vec_addr;
  logic [NIRQ-1:0]  pending_nxt;
  act_e             act;

  logic             stk_full;
  logic             stk_empty;
  logic [AW+FW-1:0] stk_top;

  jcn_ret_stack #(
    .W     (AW + FW),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   ({flag_ex, ret_addr}),
    .top   (stk_top),
    .full  (stk_full),
    .empty (stk_empty),
    .count (isr_depth)
  );

  // Lowest pending index wins.
  always_comb begin
    win_hot = '0;
    win_idx = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < NIRQ; i++) begin
      if (pending[i] && !found) begin
        found      = 1'b1;
        win_idx    = XW'(i);
        win_hot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    branch = 1'b0;
    case (op)
      OP_JMP:  branch = 1'b1;
      OP_JZ:   branch = flag_ex[FLAG_Z];
      OP_JNZ:  branch = !flag_ex[FLAG_Z];
      OP_JC:   branch = flag_ex[FLAG_C];
      OP_JNC:  branch = !flag_ex[FLAG_C];
      default: branch = 1'b0;
    endcase
  end

  // A RETI that meets a take while nested tail-chains: the stack is left
  // untouched. A RETI on an empty stack only raises the error; a
  // simultaneous take then pushes normally so its ISR can still return.
  always_comb begin
    is_reti     = (op == OP_RETI);
    take        = found && !stk_full && !shadow;
    underflow   = is_reti && stk_empty;
    push        = take && !(is_reti && !stk_empty);
    pop         = is_reti && !stk_empty && !take;
    ret_addr    = branch ? jmp_address_pm : current_address;
    vec_addr    = AW'(vec_calc(32'(VEC_BASE), VEC_STRIDE, 32'(win_idx)));
    // Clearing on ack happens before new edges are merged in.
    pending_nxt = (pending & ~(take ? win_hot : '0)) | (irq & ~irq_q);
    if (take) begin
      act = ACT_TAKE;
    end else if (pop) begin
      act = ACT_RETI;
    end else if (branch) begin
      act = ACT_BRANCH;
    end else begin
      act = ACT_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q           <= '0;
      pending         <= '0;
      shadow          <= 1'b0;
      jmp_loc         <= '0;
      pc_mux_sel      <= 1'b0;
      flag_restore    <= '0;
      flag_restore_en <= 1'b0;
      irq_ack         <= '0;
      err_underflow   <= 1'b0;
    end else begin
      irq_q           <= irq;
      pending         <= pending_nxt;
      shadow          <= take;
      pc_mux_sel      <= 1'b0;
      flag_restore_en <= 1'b0;
      irq_ack         <= '0;
      if (underflow) begin
        err_underflow <= 1'b1;
      end
      case (act)
        ACT_TAKE: begin
          jmp_loc    <= vec_addr;
          pc_mux_sel <= 1'b1;
          irq_ack    <= win_hot;
        end
        ACT_RETI: begin
          jmp_loc         <= stk_top[AW-1:0];
          flag_restore    <= stk_top[AW+FW-1:AW];
          flag_restore_en <= 1'b1;
          pc_mux_sel      <= 1'b1;
        end
        ACT_BRANCH: begin
          jmp_loc    <= jmp_address_pm;
          pc_mux_sel <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jump_control_nested.sv
// Self-checking bench for jump_control_nested: directed steps from the test
// plan followed by randomized traffic, all compared against a queue-based
// reference model of the controller's rules.
module tb_jump_control_nested;

  localparam int unsigned AW = 16;
  localparam int unsigned FW = 2;
  localparam int unsigned NIRQ = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [5:0]      op = '0;
  logic [AW-1:0]   jmp_address_pm = '0;
  logic [AW-1:0]   current_address = '0;
  logic [FW-1:0]   flag_ex = '0;
  logic [NIRQ-1:0] irq = '0;
  logic [AW-1:0]   jmp_loc;
  logic            pc_mux_sel;
  logic [FW-1:0]   flag_restore;
  logic            flag_restore_en;
  logic [NIRQ-1:0] irq_ack;
  logic [DW-1:0]   isr_depth;
  logic            err_underflow;

  jump_control_nested #(
    .AW(AW), .FW(FW), .NIRQ(NIRQ), .DEPTH(DEPTH),
    .VEC_BASE(16'h00F0), .VEC_STRIDE(4)
  ) dut (
    .clk(clk), .reset(reset), .op(op), .jmp_address_pm(jmp_address_pm),
    .current_address(current_address), .flag_ex(flag_ex), .irq(irq),
    .jmp_loc(jmp_loc), .pc_mux_sel(pc_mux_sel), .flag_restore(flag_restore),
    .flag_restore_en(flag_restore_en), .irq_ack(irq_ack),
    .isr_depth(isr_depth), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [NIRQ-1:0]   m_prev;
  logic [NIRQ-1:0]   m_pend;
  bit                m_took_last;
  logic [AW+FW-1:0]  m_stack[$];
  logic [AW-1:0]     m_jmp_loc;
  logic              m_sel;
  logic [FW-1:0]     m_fr;
  logic              m_fren;
  logic [NIRQ-1:0]   m_ack;
  logic              m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Applies one clock's worth of the controller's rules to the inputs now applied.
  task automatic model_step();
    int  w;
    bit  tk, rt, br, nested;
    logic [AW+FW-1:0] e;
    if (reset) begin
      m_prev = '0; m_pend = '0; m_took_last = 0; m_stack.delete();
      m_jmp_loc = '0; m_sel = 0; m_fr = '0; m_fren = 0; m_ack = '0; m_err = 0;
      return;
    end
    w = -1;
    for (int i = 0; i < NIRQ; i++) if (m_pend[i]) begin w = i; break; end
    tk = (w >= 0) && (m_stack.size() < DEPTH) && !m_took_last;
    rt = (op == 6'h10);
    nested = m_stack.size() > 0;
    case (op)
      6'h18: br = 1;
      6'h1E: br = flag_ex[0];
      6'h1F: br = !flag_ex[0];
      6'h1C: br = flag_ex[1];
      6'h1D: br = !flag_ex[1];
      default: br = 0;
    endcase
    m_sel = 0; m_fren = 0; m_ack = '0;
    if (rt && !nested) m_err = 1;
    if (tk) begin
      if (!(rt && nested)) m_stack.push_back({flag_ex, br ? jmp_address_pm : current_address});
      m_jmp_loc = AW'(32'h00F0 + 32'(w) * 4);
      m_sel = 1;
      m_ack[w] = 1'b1;
      m_pend[w] = 1'b0;
    end else if (rt && nested) begin
      e = m_stack.pop_back();
      m_jmp_loc = e[AW-1:0];
      m_fr = e[AW+FW-1:AW];
      m_fren = 1; m_sel = 1;
    end else if (br) begin
      m_jmp_loc = jmp_address_pm;
      m_sel = 1;
    end
    m_pend = m_pend | (irq & ~m_prev);
    m_prev = irq;
    m_took_last = tk;
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    chk({tag, ".jmp_loc"}, 32'(jmp_loc), 32'(m_jmp_loc));
    chk({tag, ".pc_mux_sel"}, 32'(pc_mux_sel), 32'(m_sel));
    chk({tag, ".flag_restore"}, 32'(flag_restore), 32'(m_fr));
    chk({tag, ".flag_restore_en"}, 32'(flag_restore_en), 32'(m_fren));
    chk({tag, ".irq_ack"}, 32'(irq_ack), 32'(m_ack));
    chk({tag, ".isr_depth"}, 32'(isr_depth), 32'(m_stack.size()));
    chk({tag, ".err_underflow"}, 32'(err_underflow), 32'(m_err));
  endtask

  logic [5:0] op_tab [9] = '{6'h18, 6'h1E, 6'h1F, 6'h1C, 6'h1D, 6'h10, 6'h10, 6'h00, 6'h05};

  initial begin
    // Reset
    reset = 1; cycle("reset"); cycle("reset");
    chk("reset_jmp_loc", 32'(jmp_loc), 0);
    chk("reset_depth", 32'(isr_depth), 0);
    reset = 0;

    // Unconditional jump, then idle
    op = 6'h18; jmp_address_pm = 16'h0008; cycle("jmp");
    chk("jmp_target", 32'(jmp_loc), 32'h0008);
    chk("jmp_sel", 32'(pc_mux_sel), 1);
    op = 6'h00; cycle("jmp_idle");
    chk("jmp_one_cycle", 32'(pc_mux_sel), 0);

    // JZ not taken then taken
    op = 6'h1E; flag_ex = 2'b00; jmp_address_pm = 16'h0010; cycle("jz_nt");
    chk("jz_nt_sel", 32'(pc_mux_sel), 0);
    flag_ex = 2'b01; cycle("jz_t");
    chk("jz_t_target", 32'(jmp_loc), 32'h0010);

    // Two simultaneous IRQs, priority and shadow cycle
    op = 6'h00; current_address = 16'h0040; flag_ex = 2'b10; irq = 4'b0110;
    cycle("irq_edge");
    cycle("irq1_take");
    chk("irq1_vec", 32'(jmp_loc), 32'h00F4);
    chk("irq1_ack", 32'(irq_ack), 32'b0010);
    chk("irq1_depth", 32'(isr_depth), 1);
    current_address = 16'h0044; flag_ex = 2'b01;
    cycle("irq_shadow");
    chk("shadow_no_take", 32'(pc_mux_sel), 0);
    cycle("irq2_take");
    chk("irq2_vec", 32'(jmp_loc), 32'h00F8);
    chk("irq2_depth", 32'(isr_depth), 2);

    // RETI x2 then underflow
    op = 6'h10; cycle("reti1");
    chk("reti1_addr", 32'(jmp_loc), 32'h0044);
    cycle("reti2");
    chk("reti2_addr", 32'(jmp_loc), 32'h0040);
    chk("reti2_flags", 32'(flag_restore), 32'b10);
    chk("reti2_en", 32'(flag_restore_en), 1);
    chk("reti2_depth", 32'(isr_depth), 0);
    cycle("reti3");
    chk("underflow_err", 32'(err_underflow), 1);
    chk("underflow_sel", 32'(pc_mux_sel), 0);

    // Fill stack, fifth request waits until a RETI frees a slot
    op = 6'h00; irq = 4'b0000; cycle("fill_low");
    irq = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      current_address = AW'(16'h0100 + i); cycle("fill");
    end
    chk("full_depth", 32'(isr_depth), 4);
    irq = 4'b1110; cycle("fifth_low");
    irq = 4'b1111; cycle("fifth_edge");
    for (int i = 0; i < 3; i++) begin
      cycle("full_wait");
      chk("full_wait_sel", 32'(pc_mux_sel), 0);
    end
    op = 6'h10; cycle("full_reti");
    chk("full_reti_depth", 32'(isr_depth), 3);
    op = 6'h00; cycle("fifth_take");
    chk("fifth_vec", 32'(jmp_loc), 32'h00F0);
    chk("fifth_ack", 32'(irq_ack), 32'b0001);
    chk("fifth_depth", 32'(isr_depth), 4);

    // Tail-chain: RETI meets a take at depth 1
    reset = 1; irq = '0; cycle("tc_reset");
    chk("tc_reset_depth", 32'(isr_depth), 0);
    reset = 0; irq = 4'b0010; cycle("tc_edge");
    cycle("tc_take1");
    cycle("tc_shadow");
    irq = 4'b0011; cycle("tc_edge0");
    op = 6'h10; cycle("tc_chain");
    chk("tc_vec", 32'(jmp_loc), 32'h00F0);
    chk("tc_depth", 32'(isr_depth), 1);
    chk("tc_fren", 32'(flag_restore_en), 0);
    op = 6'h00;

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 63) == 0);
      op = op_tab[$urandom_range(0, 8)];
      flag_ex = FW'($urandom);
      jmp_address_pm = AW'($urandom);
      current_address = AW'($urandom);
      irq = irq ^ NIRQ'($urandom & $urandom & $urandom);
      cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
